seq_mag_comparator: RTL and testbench

Parametrised, cascadable magnitude comparator that compares two WIDTH-bit operands serially, one DIGIT-bit slice per clock, most significant slice first. It supports unsigned and two's-complement modes, stops early at the first differing slice, and forwards cascade inputs when the operands are fully equal. It is the multi-cycle, area-lean successor to the single-slice combinational comparator. It sits between operand registers and any control logic that needs a registered lt/eq/gt verdict with a start/done handshake.

---
 rtl/cmp_pkg.sv | 17 +
 rtl/mag_slice_cmp.sv | 16 +
 rtl/seq_mag_comparator.sv | 122 ++++++++++++
 tb/tb_seq_mag_comparator.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM state, verdict triple.
package cmp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_e;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } res_t;

    localparam res_t RES_NONE = 3'b000;

endpackage

// File: rtl/mag_slice_cmp.sv
// Combinational DIGIT-bit unsigned compare of one operand slice.
module mag_slice_cmp #(
    parameter int DIGIT = 3
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    assign lt = (a < b);
    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/seq_mag_comparator.sv
// Serial MSB-first magnitude comparator, one DIGIT slice per clock, early exit
// on the first differing slice, cascade inputs forwarded on full equality.
module seq_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DIGIT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             signed_mode,
    input  logic             l,
    input  logic             e,
    input  logic             g,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_width
        $error("seq_mag_comparator: WIDTH must be a positive multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    res_t             cas_q, cas_d;
    res_t             res_q, res_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] sign_flip;
    logic [DIGIT-1:0] a_sl, b_sl;
    logic             s_lt, s_eq, s_gt;

    assign a_sl = a_q[idx_q*DIGIT +: DIGIT];
    assign b_sl = b_q[idx_q*DIGIT +: DIGIT];

    mag_slice_cmp #(.DIGIT(DIGIT)) u_slice (
        .a  (a_sl),
        .b  (b_sl),
        .lt (s_lt),
        .eq (s_eq),
        .gt (s_gt)
    );

    // Flipping the sign bit of both operands maps two's-complement order
    // onto unsigned order, so the slice compare stays unsigned.
    always_comb begin
        sign_flip            = '0;
        sign_flip[WIDTH-1]   = signed_mode;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        cas_d   = cas_q;
        res_d   = res_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A ^ sign_flip;
                    b_d     = B ^ sign_flip;
                    cas_d   = {l, e, g};
                    idx_d   = IDX_W'(NSLICE - 1);
                    state_d = CMP;
                end
            end
            CMP: begin
                if (!s_eq) begin
                    res_d   = '{lt: s_lt, eq: 1'b0, gt: s_gt};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    res_d   = cas_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cas_q   <= RES_NONE;
            res_q   <= RES_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cas_q   <= cas_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == CMP);
    assign done = done_q;
    assign lt   = res_q.lt;
    assign eq   = res_q.eq;
    assign gt   = res_q.gt;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Randomised self-checking bench: a 12/3 instance for latency, cascade and
// reset behaviour, and a 3/3 instance for back-to-back single-slice compares.
module tb_seq_mag_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start12 = 1'b0, sm12 = 1'b0, l12 = 1'b0, e12 = 1'b0, g12 = 1'b0;
    logic [11:0] a12 = '0, b12 = '0;
    logic        busy12, done12, lt12, eq12, gt12;

    logic        start3 = 1'b0, sm3 = 1'b0, l3 = 1'b0, e3 = 1'b0, g3 = 1'b0;
    logic [2:0]  a3 = '0, b3 = '0;
    logic        busy3, done3, lt3, eq3, gt3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_mag_comparator #(.WIDTH(12), .DIGIT(3)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .start(start12), .A(a12), .B(b12),
        .signed_mode(sm12), .l(l12), .e(e12), .g(g12),
        .busy(busy12), .done(done12), .lt(lt12), .eq(eq12), .gt(gt12)
    );

    seq_mag_comparator #(.WIDTH(3), .DIGIT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .A(a3), .B(b3),
        .signed_mode(sm3), .l(l3), .e(e3), .g(g3),
        .busy(busy3), .done(done3), .lt(lt3), .eq(eq3), .gt(gt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference verdict from integer values of the operands.
    function automatic logic [2:0] ref_res(input longint a, input longint b, input logic sm,
                                           input logic [2:0] lge, input int w);
        longint va, vb;
        va = a;
        vb = b;
        if (sm) begin
            if (a >= (longint'(1) << (w - 1))) va = a - (longint'(1) << w);
            if (b >= (longint'(1) << (w - 1))) vb = b - (longint'(1) << w);
        end
        if (va < vb) return 3'b100;
        if (va > vb) return 3'b001;
        return lge;
    endfunction

    // Compare edges needed: slices from the top down to the highest differing bit.
    function automatic int ref_k(input longint a, input longint b, input int w, input int d);
        longint x;
        int     h;
        x = a ^ b;
        if (x == 0) return w / d;
        h = 0;
        for (int i = 0; i < w; i++) if (x[i]) h = i;
        return w / d - h / d;
    endfunction

    task automatic run12(input string tag, input logic [11:0] a, input logic [11:0] b,
                         input logic sm, input logic [2:0] lge, input bit inject);
        logic [2:0] exp;
        int         k, cyc, guard;
        exp = ref_res(longint'(a), longint'(b), sm, lge, 12);
        k   = ref_k(longint'(a), longint'(b), 12, 3);
        @(negedge clk);
        a12 = a; b12 = b; sm12 = sm; {l12, e12, g12} = lge; start12 = 1'b1;
        @(negedge clk);
        start12 = 1'b0;
        cyc = 0;
        guard = 0;
        while (!done12 && guard < 40) begin
            if (busy12) cyc++;
            if (inject && cyc == 1) begin
                a12 = 12'hFFF; b12 = 12'h000; sm12 = ~sm; start12 = 1'b1;
            end else begin
                start12 = 1'b0;
            end
            guard++;
            @(negedge clk);
        end
        start12 = 1'b0;
        chk({tag, "_done_seen"}, 32'(done12), 32'(1));
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'(k));
        chk({tag, "_busy_low_at_done"}, 32'(busy12), 32'(0));
        chk({tag, "_result"}, 32'({lt12, eq12, gt12}), 32'(exp));
        @(negedge clk);
        chk({tag, "_done_pulse_width"}, 32'(done12), 32'(0));
        chk({tag, "_result_hold"}, 32'({lt12, eq12, gt12}), 32'(exp));
    endtask

    initial begin
        logic [11:0] ra, rb;
        logic [2:0]  pa, pb, plge;
        logic        psm;
        logic [2:0]  exp3;
        bit          done_seen;

        repeat (2) @(negedge clk);
        chk("reset12_outs", 32'({busy12, done12, lt12, eq12, gt12}), 32'(0));
        chk("reset3_outs", 32'({busy3, done3, lt3, eq3, gt3}), 32'(0));
        rst_n = 1'b1;

        run12("uns_800_7ff", 12'h800, 12'h7FF, 1'b0, 3'b000, 1'b0);
        run12("sgn_800_7ff", 12'h800, 12'h7FF, 1'b1, 3'b000, 1'b0);
        run12("eq_cas_010", 12'h5A5, 12'h5A5, 1'b0, 3'b010, 1'b0);
        run12("eq_cas_100", 12'h5A5, 12'h5A5, 1'b0, 3'b100, 1'b0);
        run12("eq_cas_111", 12'h3C3, 12'h3C3, 1'b1, 3'b111, 1'b0);
        run12("eq_cas_000", 12'h000, 12'h000, 1'b0, 3'b000, 1'b0);
        run12("lsb_diff_inject", 12'h5A4, 12'h5A5, 1'b0, 3'b001, 1'b1);

        // Abort in the middle of a compare; result was lt=1 before this.
        @(negedge clk);
        a12 = 12'h5A4; b12 = 12'h5A5; sm12 = 1'b0; {l12, e12, g12} = 3'b001; start12 = 1'b1;
        @(negedge clk);
        start12 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_outs_clear", 32'({busy12, lt12, eq12, gt12}), 32'(0));
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done12) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done12) done_seen = 1'b1;
        end
        chk("abort_no_done", 32'(done_seen), 32'(0));
        run12("after_abort", 12'h123, 12'h122, 1'b0, 3'b000, 1'b0);

        // Random pairs that differ at a random depth, both modes.
        for (int i = 0; i < 40; i++) begin
            ra = 12'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ 12'($urandom_range(1, 7));
                2:       rb = ra ^ 12'($urandom_range(1, 511));
                default: rb = 12'($urandom);
            endcase
            run12($sformatf("rand12_%0d", i), ra, rb, 1'($urandom), 3'($urandom), 1'b0);
        end

        // Single-slice instance: each new start lands in the previous done cycle.
        @(negedge clk);
        pa = 3'($urandom); pb = 3'($urandom); psm = 1'($urandom); plge = 3'($urandom);
        a3 = pa; b3 = pb; sm3 = psm; {l3, e3, g3} = plge; start3 = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            start3 = 1'b0;
            chk("b2b_busy", 32'({busy3, done3}), 32'(2'b10));
            @(negedge clk);
            exp3 = ref_res(longint'(pa), longint'(pb), psm, plge, 3);
            chk("b2b_done", 32'({busy3, done3}), 32'(2'b01));
            chk($sformatf("b2b_res_%0d", i), 32'({lt3, eq3, gt3}), 32'(exp3));
            if (i < 999) begin
                pa = 3'($urandom); pb = 3'($urandom); psm = 1'($urandom); plge = 3'($urandom);
                a3 = pa; b3 = pb; sm3 = psm; {l3, e3, g3} = plge; start3 = 1'b1;
            end
        end
        @(negedge clk);
        chk("b2b_final_idle", 32'({busy3, done3}), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
